// File: rtl/dma_host_responder_pkg.sv
// Shared types and constants for the DMA host responder.
// Line addresses are cacheline indices; byte address bits below LINE_OFFSET_BITS are ignored.
package dma_resp_pkg;

  localparam int LINE_OFFSET_BITS = 6;
  localparam int CNT_WIDTH        = 43;
  localparam int IDX_WIDTH        = 10;

  typedef logic [CNT_WIDTH-1:0] count_t;
  typedef logic [IDX_WIDTH-1:0] line_idx_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_STREAM,
    R_DONE
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ACTIVE,
    W_DONE
  } wr_state_t;

endpackage

// File: rtl/dma_host_responder_if.sv
// DMA request/response bundle between the AFU/MMU (master) and the host responder (slave).
// proto_err exists only when DMA_RESP_PROTO_CHECK_EN is defined.
interface dma_host_responder_if #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 64,
  parameter int SIZE_WIDTH     = 43,
  parameter int MEM_LINES_LOG2 = 10
);

  logic                      rd_go;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [SIZE_WIDTH-1:0]     rd_size;
  logic                      rd_en;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      empty;
  logic                      rd_done;

  logic                      wr_go;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [SIZE_WIDTH-1:0]     wr_size;
  logic                      wr_en;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      full;
  logic                      wr_done;
  logic                      host_wr_completed;

  logic                      bd_we;
  logic [MEM_LINES_LOG2-1:0] bd_line;
  logic [DATA_WIDTH-1:0]     bd_data;

`ifdef DMA_RESP_PROTO_CHECK_EN
  logic                      proto_err;
`endif

  modport master (
    output rd_go, rd_addr, rd_size, rd_en,
    input  rd_data, empty, rd_done,
    output wr_go, wr_addr, wr_size, wr_en, wr_data,
    input  full, wr_done, host_wr_completed,
    output bd_we, bd_line, bd_data
`ifdef DMA_RESP_PROTO_CHECK_EN
    , input proto_err
`endif
  );

  modport slave (
    input  rd_go, rd_addr, rd_size, rd_en,
    output rd_data, empty, rd_done,
    input  wr_go, wr_addr, wr_size, wr_en, wr_data,
    output full, wr_done, host_wr_completed,
    input  bd_we, bd_line, bd_data
`ifdef DMA_RESP_PROTO_CHECK_EN
    , output proto_err
`endif
  );

endinterface

// File: rtl/dma_resp_fifo.sv
// Show-ahead FIFO: o_head presents the oldest entry without a pop, and reads 0 while empty.
// Flush discards all entries and wins over a same-cycle push/pop.
module dma_resp_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_store [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = o_empty ? '0 : r_store[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_store[r_wptr] <= i_push_data;
  end

endmodule

// File: rtl/dma_host_responder.sv
// Host-side DMA responder: read and write channels backed by an on-chip cacheline memory.
// Define DMA_RESP_PROTO_CHECK_EN to add the sticky proto_err output.
module dma_host_responder
  import dma_resp_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 64,
  parameter int SIZE_WIDTH     = CNT_WIDTH,
  parameter int MEM_LINES_LOG2 = IDX_WIDTH,
  parameter int RD_FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dma_host_responder_if.slave  bus
);

  localparam int FCW = $clog2(RD_FIFO_DEPTH) + 1;

  rd_state_t             r_rd_state, w_rd_state_nxt;
  wr_state_t             r_wr_state, w_wr_state_nxt;
  count_t                r_rd_size, r_issued, r_popped;
  count_t                r_wr_size, r_written;
  line_idx_t             r_rd_idx, r_wr_idx;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_mem_q;
  logic [DATA_WIDTH-1:0] r_mem [2**MEM_LINES_LOG2];

  logic [DATA_WIDTH-1:0] w_fifo_head;
  logic [FCW-1:0]        w_fifo_count;
  logic [FCW-1:0]        w_occ;
  logic                  w_empty, w_fifo_full;
  logic                  w_issue, w_pop, w_push, w_commit;
  logic                  w_rd_done, w_full, w_wr_done;
  logic                  w_unused;

  // A line in flight already owns a FIFO slot, so issue never overruns the FIFO.
  assign w_occ    = w_fifo_count + FCW'(r_inflight);
  assign w_pop    = bus.rd_en && !w_empty;
  assign w_push   = r_inflight && !bus.rd_go;
  assign w_issue  = (r_rd_state == R_STREAM) && !bus.rd_go &&
                    (r_issued < r_rd_size) && (w_occ < FCW'(RD_FIFO_DEPTH));
  assign w_commit = (r_wr_state == W_ACTIVE) && bus.wr_en && !bus.wr_go;

  assign w_unused = ^{bus.rd_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS+MEM_LINES_LOG2],
                      bus.rd_addr[LINE_OFFSET_BITS-1:0],
                      bus.wr_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS+MEM_LINES_LOG2],
                      bus.wr_addr[LINE_OFFSET_BITS-1:0], w_fifo_full};

  // DMA write commit owns the write port; a colliding backdoor write is dropped.
  always_ff @(posedge clk) begin
    if (w_issue) r_mem_q <= r_mem[r_rd_idx];
    if (w_commit)        r_mem[r_wr_idx]  <= bus.wr_data;
    else if (bus.bd_we)  r_mem[bus.bd_line] <= bus.bd_data;
  end

  dma_resp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (bus.rd_go),
    .i_push      (w_push),
    .i_push_data (r_mem_q),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_empty),
    .o_full      (w_fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= R_IDLE;
      r_wr_state <= W_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    if (bus.rd_go)
      w_rd_state_nxt = (bus.rd_size != '0) ? R_STREAM : R_DONE;
    else if ((r_rd_state == R_STREAM) && w_pop && (r_popped + count_t'(1) == r_rd_size))
      w_rd_state_nxt = R_DONE;
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    if (bus.wr_go)
      w_wr_state_nxt = (bus.wr_size != '0) ? W_ACTIVE : W_DONE;
    else if (w_commit && (r_written + count_t'(1) == r_wr_size))
      w_wr_state_nxt = W_DONE;
  end

  always_comb begin
    w_rd_done = (r_rd_state == R_DONE);
    w_full    = 1'b1;
    w_wr_done = 1'b0;
    case (r_wr_state)
      W_ACTIVE: w_full    = 1'b0;
      W_DONE:   w_wr_done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_idx   <= '0;
      r_rd_size  <= '0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_inflight <= 1'b0;
    end else if (bus.rd_go) begin
      r_rd_idx   <= bus.rd_addr[LINE_OFFSET_BITS +: MEM_LINES_LOG2];
      r_rd_size  <= bus.rd_size;
      r_issued   <= '0;
      r_popped   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_idx <= r_rd_idx + 1'b1;
        r_issued <= r_issued + count_t'(1);
      end
      if (w_pop) r_popped <= r_popped + count_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx  <= '0;
      r_wr_size <= '0;
      r_written <= '0;
    end else if (bus.wr_go) begin
      r_wr_idx  <= bus.wr_addr[LINE_OFFSET_BITS +: MEM_LINES_LOG2];
      r_wr_size <= bus.wr_size;
      r_written <= '0;
    end else if (w_commit) begin
      r_wr_idx  <= r_wr_idx + 1'b1;
      r_written <= r_written + count_t'(1);
    end
  end

  assign bus.rd_data           = w_fifo_head;
  assign bus.empty             = w_empty;
  assign bus.rd_done           = w_rd_done;
  assign bus.full              = w_full;
  assign bus.wr_done           = w_wr_done;
  assign bus.host_wr_completed = w_wr_done;

`ifdef DMA_RESP_PROTO_CHECK_EN
  logic r_proto_err;
  logic w_proto_evt;

  assign w_proto_evt = (bus.rd_en && w_empty) || (bus.wr_en && w_full) ||
                       (bus.rd_go && (r_rd_state == R_STREAM)) ||
                       (bus.wr_go && (r_wr_state == W_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_proto_err <= 1'b0;
    else if (w_proto_evt) r_proto_err <= 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && w_proto_evt) $error("dma_host_responder: DMA protocol violation");
  end
`endif

  assign bus.proto_err = r_proto_err;
`endif

endmodule

// File: tb/tb_dma_host_responder.sv
// Directed bench for dma_host_responder: table-driven read stream plus hand-written corner sequences.
module tb_dma_host_responder;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int SW = 43;
  localparam int ML = 10;
  localparam int FD = 4;

  typedef logic [DW-1:0] line_t;

  typedef struct {
    logic go;
    logic en;
    logic exp_empty;
    logic exp_done;
    int   exp_data;
  } rd_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  line_t exp_q[$];

  always #5 clk = ~clk;

  dma_host_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .MEM_LINES_LOG2(ML)) bus ();

  dma_host_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .MEM_LINES_LOG2(ML), .RD_FIFO_DEPTH(FD)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input line_t act, input line_t exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input int line, input line_t d);
    bus.bd_we   = 1'b1;
    bus.bd_line = ML'(line);
    bus.bd_data = d;
    tick();
    bus.bd_we   = 1'b0;
  endtask

  // Holds rd_en high and compares every visible head against exp_q until rd_done or budget runs out.
  task automatic read_stream(input string name, input logic start, input logic [AW-1:0] addr, input int size);
    int got = 0;
    int budget = 0;
    if (start) begin
      bus.rd_go   = 1'b1;
      bus.rd_addr = addr;
      bus.rd_size = SW'(size);
      bus.rd_en   = 1'b1;
      tick();
      bus.rd_go   = 1'b0;
    end
    bus.rd_en = 1'b1;
    while (bus.rd_done !== 1'b1 && budget < 64) begin
      if (bus.empty === 1'b0) begin
        if (got < exp_q.size()) check($sformatf("%s[%0d]", name, got), bus.rd_data, exp_q[got]);
        got++;
      end
      tick();
      budget++;
    end
    bus.rd_en = 1'b0;
    check({name, "_count"}, line_t'(got), line_t'(exp_q.size()));
    check({name, "_rd_done"}, line_t'(bus.rd_done), line_t'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t tbl[12];

    bus.rd_go = 0; bus.rd_addr = '0; bus.rd_size = '0; bus.rd_en = 0;
    bus.wr_go = 0; bus.wr_addr = '0; bus.wr_size = '0; bus.wr_en = 0; bus.wr_data = '0;
    bus.bd_we = 0; bus.bd_line = '0; bus.bd_data = '0;

    tick();
    tick();
    check("rst_empty",   line_t'(bus.empty),             line_t'(1));
    check("rst_full",    line_t'(bus.full),              line_t'(1));
    check("rst_rd_done", line_t'(bus.rd_done),           line_t'(0));
    check("rst_wr_done", line_t'(bus.wr_done),           line_t'(0));
    check("rst_hwc",     line_t'(bus.host_wr_completed), line_t'(0));
    check("rst_rd_data", bus.rd_data,                    line_t'(0));
    rst_n = 1'b1;
    tick();

    // Sequential read of lines 0..7 with rd_en held high
    for (int i = 0; i < 8; i++) bd_write(i, line_t'(i));
    tbl[0]  = '{go: 1'b1, en: 1'b1, exp_empty: 1'b1, exp_done: 1'b0, exp_data: 0};
    tbl[1]  = '{go: 1'b0, en: 1'b1, exp_empty: 1'b1, exp_done: 1'b0, exp_data: 0};
    for (int k = 0; k < 8; k++)
      tbl[2+k] = '{go: 1'b0, en: 1'b1, exp_empty: 1'b0, exp_done: 1'b0, exp_data: k};
    tbl[10] = '{go: 1'b0, en: 1'b1, exp_empty: 1'b1, exp_done: 1'b1, exp_data: 0};
    tbl[11] = '{go: 1'b0, en: 1'b0, exp_empty: 1'b1, exp_done: 1'b1, exp_data: 0};
    bus.rd_addr = '0;
    bus.rd_size = SW'(8);
    for (int i = 0; i < 12; i++) begin
      bus.rd_go = tbl[i].go;
      bus.rd_en = tbl[i].en;
      tick();
      check($sformatf("seq_empty[%0d]", i), line_t'(bus.empty),   line_t'(tbl[i].exp_empty));
      check($sformatf("seq_done[%0d]", i),  line_t'(bus.rd_done), line_t'(tbl[i].exp_done));
      check($sformatf("seq_data[%0d]", i),  bus.rd_data,          line_t'(tbl[i].exp_data));
    end
    bus.rd_go = 0;
    bus.rd_en = 0;

    // Write 0xA..0xD at 0x1000, then read it back
    bus.wr_go = 1; bus.wr_addr = 64'h1000; bus.wr_size = SW'(4);
    tick();
    bus.wr_go = 0;
    check("wr_full_active", line_t'(bus.full),    line_t'(0));
    check("wr_done_active", line_t'(bus.wr_done), line_t'(0));
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1; bus.wr_data = line_t'(32'hA + i);
      tick();
      if (i < 3) begin
        check($sformatf("wr_full[%0d]", i), line_t'(bus.full),    line_t'(0));
        check($sformatf("wr_done[%0d]", i), line_t'(bus.wr_done), line_t'(0));
      end else begin
        check("wr_done_final", line_t'(bus.wr_done),           line_t'(1));
        check("wr_hwc_final",  line_t'(bus.host_wr_completed), line_t'(1));
        check("wr_full_final", line_t'(bus.full),              line_t'(1));
      end
    end
    bus.wr_en = 0;
    exp_q = {};
    for (int i = 0; i < 4; i++) exp_q.push_back(line_t'(32'hA + i));
    read_stream("wr_readback", 1'b1, 64'h1000, 4);

    // Zero-size transfers on both channels in one cycle; wr_en meanwhile must not write
    bus.rd_go = 1; bus.rd_size = '0; bus.rd_addr = 64'h1000;
    bus.wr_go = 1; bus.wr_size = '0; bus.wr_addr = 64'h1000;
    bus.wr_en = 1; bus.wr_data = line_t'(32'hFFFF);
    tick();
    bus.rd_go = 0; bus.wr_go = 0;
    check("zero_rd_done", line_t'(bus.rd_done), line_t'(1));
    check("zero_wr_done", line_t'(bus.wr_done), line_t'(1));
    check("zero_empty",   line_t'(bus.empty),   line_t'(1));
    check("zero_full",    line_t'(bus.full),    line_t'(1));
    tick();
    bus.wr_en = 0;
    exp_q = {};
    exp_q.push_back(line_t'(32'hA));
    read_stream("zero_nowrite", 1'b1, 64'h1000, 1);

    // Backpressure: 10 lines with rd_en low, FIFO caps at its depth
    for (int i = 0; i < 10; i++) bd_write(100 + i, line_t'(32'h100 + i));
    bus.rd_go = 1; bus.rd_addr = 64'(100 * 64); bus.rd_size = SW'(10); bus.rd_en = 0;
    tick();
    bus.rd_go = 0;
    repeat (10) tick();
    check("bp_empty",   line_t'(bus.empty),                  line_t'(0));
    check("bp_head",    bus.rd_data,                         line_t'(32'h100));
    check("bp_count",   line_t'(u_dut.u_rd_fifo.o_count),    line_t'(FD));
    check("bp_rd_done", line_t'(bus.rd_done),                line_t'(0));
    exp_q = {};
    for (int i = 0; i < 10; i++) exp_q.push_back(line_t'(32'h100 + i));
    read_stream("bp_drain", 1'b0, '0, 10);

    // Index wrap from line 1022
    bd_write(1022, line_t'(32'h3FE));
    bd_write(1023, line_t'(32'h3FF));
    exp_q = {};
    exp_q.push_back(line_t'(32'h3FE));
    exp_q.push_back(line_t'(32'h3FF));
    exp_q.push_back(line_t'(0));
    exp_q.push_back(line_t'(1));
    read_stream("wrap", 1'b1, 64'(1022 * 64), 4);

    // Reset after 3 of 8 writes, then a clean transfer (with a colliding backdoor write)
    bus.wr_go = 1; bus.wr_addr = 64'h2000; bus.wr_size = SW'(8);
    tick();
    bus.wr_go = 0;
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1; bus.wr_data = line_t'(32'h5A + i);
      tick();
    end
    bus.wr_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_full",    line_t'(bus.full),              line_t'(1));
    check("rstmid_wr_done", line_t'(bus.wr_done),           line_t'(0));
    check("rstmid_hwc",     line_t'(bus.host_wr_completed), line_t'(0));
    tick();
    rst_n = 1'b1;
    tick();
    bus.wr_go = 1; bus.wr_addr = 64'h2000; bus.wr_size = SW'(8);
    tick();
    bus.wr_go = 0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1; bus.wr_data = line_t'(32'h200 + i);
      bus.bd_we = (i == 0); bus.bd_line = ML'(128); bus.bd_data = line_t'(32'hDEAD);
      tick();
      bus.bd_we = 0;
      if (i == 6) check("rew_done_partial", line_t'(bus.wr_done), line_t'(0));
      if (i == 7) check("rew_done",         line_t'(bus.wr_done), line_t'(1));
    end
    bus.wr_en = 0;
    exp_q = {};
    for (int i = 0; i < 8; i++) exp_q.push_back(line_t'(32'h200 + i));
    read_stream("rew_readback", 1'b1, 64'h2000, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
